uart_rx_fsm: RTL and testbench

UART_RX_FSM -- requirements
Module: uart_rx_fsm

---
 rtl/uart_rx_fsm.sv | 116 +++++++++++
 tb/tb_uart_rx_fsm.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// UART receive controller: sequences start/data/parity/stop bits against an
// external edge/bit counter and emits check strobes plus a frame-valid pulse.
module uart_rx_fsm #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rx_in,
    input  logic                  par_en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [3:0]            bit_cnt,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic                  edge_bit_cnt_en,
    output logic                  dat_samp_en,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  deser_en,
    output logic                  data_valid,
    output logic                  rx_busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    state_t state, next_state;
    logic   err_flag;

    logic [PRESCALE_W-1:0] ps_even;
    logic [PRESCALE_W-1:0] end_edge;
    logic [PRESCALE_W-1:0] chk_edge;
    logic                  bit_end;
    logic                  chk_pt;

    // The ratio is always even; masking bit 0 keeps odd inputs from shifting the sample points.
    assign ps_even  = prescale & ~PRESCALE_W'(1);
    assign end_edge = ps_even - PRESCALE_W'(1);
    assign chk_edge = (ps_even >> 1) + PRESCALE_W'(2);
    assign bit_end  = (edge_cnt == end_edge);
    assign chk_pt   = (edge_cnt == chk_edge);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            err_flag <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == START && state != START)
                err_flag <= 1'b0;
            else if (state == PARITY && bit_end)
                err_flag <= par_err;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (!rx_in) next_state = START;
            START:  if (bit_end) next_state = strt_glitch ? IDLE : DATA;
            DATA:   if (bit_end && bit_cnt == 4'd8) next_state = par_en ? PARITY : STOP;
            PARITY: if (bit_end) next_state = STOP;
            STOP:   if (bit_end) next_state = (!stp_err && !err_flag) ? DONE : IDLE;
            DONE:   next_state = rx_in ? IDLE : START;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        edge_bit_cnt_en = 1'b0;
        dat_samp_en     = 1'b0;
        strt_chk_en     = 1'b0;
        par_chk_en      = 1'b0;
        stp_chk_en      = 1'b0;
        deser_en        = 1'b0;
        data_valid      = 1'b0;
        rx_busy         = (state != IDLE);
        case (state)
            START: begin
                edge_bit_cnt_en = 1'b1;
                dat_samp_en     = 1'b1;
                strt_chk_en     = chk_pt;
            end
            DATA: begin
                edge_bit_cnt_en = 1'b1;
                dat_samp_en     = 1'b1;
                deser_en        = chk_pt;
            end
            PARITY: begin
                edge_bit_cnt_en = 1'b1;
                dat_samp_en     = 1'b1;
                par_chk_en      = chk_pt;
            end
            STOP: begin
                edge_bit_cnt_en = 1'b1;
                dat_samp_en     = 1'b1;
                stp_chk_en      = chk_pt;
            end
            DONE:    data_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm with a behavioural edge/bit counter and
// pulse counters observed on the falling clock edge.
module tb_uart_rx_fsm;

    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          rx_in = 1'b1;
    logic          par_en = 1'b0;
    logic [PW-1:0] prescale = 6'd8;
    logic [PW-1:0] edge_cnt;
    logic [3:0]    bit_cnt;
    logic          strt_glitch = 1'b0;
    logic          par_err = 1'b0;
    logic          stp_err = 1'b0;
    logic          edge_bit_cnt_en, dat_samp_en, strt_chk_en, par_chk_en;
    logic          stp_chk_en, deser_en, data_valid, rx_busy;
    logic          force_stale = 1'b0;

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    int n_strt = 0, n_deser = 0, n_par = 0, n_stp = 0, n_dv = 0;
    int n_bad_deser = 0, n_bad_idle = 0;
    int last_stop_end = 0, dv_gap = -1;
    bit in_stop = 1'b0;

    uart_rx_fsm #(.PRESCALE_W(PW)) dut (
        .CLK(CLK), .RST(RST), .rx_in(rx_in), .par_en(par_en),
        .prescale(prescale), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
        .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
        .edge_bit_cnt_en(edge_bit_cnt_en), .dat_samp_en(dat_samp_en),
        .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
        .stp_chk_en(stp_chk_en), .deser_en(deser_en),
        .data_valid(data_valid), .rx_busy(rx_busy)
    );

    always #5 CLK = ~CLK;

    // External edge/bit counter the FSM expects to be driving.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (force_stale) begin
            edge_cnt <= (prescale >> 1) + 6'd2;
            bit_cnt  <= 4'd8;
        end else if (!edge_bit_cnt_en) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (edge_cnt == prescale - 6'd1) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + 6'd1;
        end
    end

    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (strt_chk_en) n_strt <= n_strt + 1;
        if (deser_en)    n_deser <= n_deser + 1;
        if (par_chk_en)  n_par <= n_par + 1;
        if (stp_chk_en)  n_stp <= n_stp + 1;
        if (data_valid) begin
            n_dv   <= n_dv + 1;
            dv_gap <= cyc - last_stop_end;
        end
        if (deser_en && edge_cnt != (prescale >> 1) + 6'd2) n_bad_deser <= n_bad_deser + 1;
        if ((strt_chk_en | deser_en | par_chk_en | stp_chk_en | edge_bit_cnt_en | dat_samp_en)
            && (!rx_busy || data_valid))
            n_bad_idle <= n_bad_idle + 1;
        if (stp_chk_en) in_stop <= 1'b1;
        else if (!edge_bit_cnt_en) in_stop <= 1'b0;
        if (in_stop && edge_bit_cnt_en && edge_cnt == prescale - 6'd1) last_stop_end <= cyc;
    end

    function automatic logic [7:0] outs();
        return {edge_bit_cnt_en, dat_samp_en, strt_chk_en, par_chk_en,
                stp_chk_en, deser_en, data_valid, rx_busy};
    endfunction

    // Drives one frame; returns pulse-count deltas once the FSM leaves the frame.
    task automatic run_frame(input int ps, input bit pe, input bit gl, input bit perr,
                             input bit serr, input bit b2b, input int flip_bit,
                             output int d_strt, output int d_deser, output int d_par,
                             output int d_stp, output int d_dv, output bit timeout);
        int s_strt, s_deser, s_par, s_stp, s_dv;
        bit flipped;
        s_strt = n_strt; s_deser = n_deser; s_par = n_par; s_stp = n_stp; s_dv = n_dv;
        flipped = 1'b0;
        timeout = 1'b1;
        prescale = PW'(ps);
        par_en = pe; strt_glitch = gl; par_err = perr; stp_err = serr;
        rx_in = 1'b0;
        repeat (2) @(negedge CLK);
        rx_in = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (flip_bit != 0 && !flipped && bit_cnt == 4'(flip_bit)) begin
                par_en = ~par_en;
                flipped = 1'b1;
            end
            if (b2b && data_valid) begin
                rx_in = 1'b0;
                timeout = 1'b0;
                break;
            end
            if (!rx_busy) begin
                timeout = 1'b0;
                break;
            end
        end
        @(negedge CLK);
        #1;
        d_strt = n_strt - s_strt; d_deser = n_deser - s_deser; d_par = n_par - s_par;
        d_stp = n_stp - s_stp; d_dv = n_dv - s_dv;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        rx_in = 1'b1;
        #12;
        checks++;
        if (outs() !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 00000000", outs());
        end
        rx_in = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (outs() !== 8'h00) begin
            failures++;
            $display("FAIL reset_hold_rx_low: got %b want 00000000", outs());
        end
        rx_in = 1'b1;
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_release: rx_busy got %b want 0", rx_busy);
        end
    endtask

    task automatic test_valid_frame();
        int a, b, c, d, e;
        bit to;
        run_frame(8, 0, 0, 0, 0, 0, 0, a, b, c, d, e, to);
        checks++;
        if (to || a != 1 || b != 8 || c != 0 || d != 1 || e != 1) begin
            failures++;
            $display("FAIL valid_frame: to=%0d strt=%0d deser=%0d par=%0d stp=%0d dv=%0d want 0 1 8 0 1 1",
                     to, a, b, c, d, e);
        end
        checks++;
        if (dv_gap != 1) begin
            failures++;
            $display("FAIL dv_latency: got %0d cycles after stop END want 1", dv_gap);
        end
        checks++;
        if (rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL valid_frame_idle: rx_busy got %b want 0", rx_busy);
        end
    endtask

    task automatic test_start_glitch();
        int a, b, c, d, e;
        bit to;
        run_frame(8, 0, 1, 0, 0, 0, 0, a, b, c, d, e, to);
        checks++;
        if (to || a != 1 || b != 0 || d != 0 || e != 0 || rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL start_glitch: to=%0d strt=%0d deser=%0d stp=%0d dv=%0d busy=%b want 0 1 0 0 0 0",
                     to, a, b, d, e, rx_busy);
        end
    endtask

    task automatic test_parity_err();
        int a, b, c, d, e;
        bit to;
        run_frame(16, 1, 0, 1, 0, 0, 0, a, b, c, d, e, to);
        checks++;
        if (to || b != 8 || c != 1 || d != 1 || e != 0) begin
            failures++;
            $display("FAIL parity_err: to=%0d deser=%0d par=%0d stp=%0d dv=%0d want 0 8 1 1 0",
                     to, b, c, d, e);
        end
    endtask

    task automatic test_stop_err();
        int a, b, c, d, e;
        bit to;
        run_frame(32, 0, 0, 0, 1, 0, 0, a, b, c, d, e, to);
        checks++;
        if (to || d != 1 || e != 0) begin
            failures++;
            $display("FAIL stop_err: to=%0d stp=%0d dv=%0d want 0 1 0", to, d, e);
        end
        run_frame(32, 1, 0, 0, 0, 0, 0, a, b, c, d, e, to);
        checks++;
        if (to || b != 8 || c != 1 || e != 1) begin
            failures++;
            $display("FAIL stop_err_recover: to=%0d deser=%0d par=%0d dv=%0d want 0 8 1 1", to, b, c, e);
        end
    endtask

    task automatic test_back_to_back();
        int a, b, c, d, e, e2;
        bit to, to2;
        run_frame(8, 0, 0, 0, 0, 1, 0, a, b, c, d, e, to);
        checks++;
        if (edge_bit_cnt_en !== 1'b1 || rx_busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_direct_start: cnt_en=%b busy=%b want 1 1", edge_bit_cnt_en, rx_busy);
        end
        run_frame(8, 0, 0, 0, 0, 0, 0, a, b, c, d, e2, to2);
        checks++;
        if (to || to2 || e + e2 != 2 || b != 8) begin
            failures++;
            $display("FAIL b2b_count: to=%0d/%0d dv=%0d deser2=%0d want 0/0 2 8", to, to2, e + e2, b);
        end
    endtask

    task automatic test_par_en_sampling();
        int a, b, c, d, e;
        bit to;
        run_frame(8, 0, 0, 0, 0, 0, 5, a, b, c, d, e, to);
        checks++;
        if (to || c != 1 || e != 1) begin
            failures++;
            $display("FAIL par_en_late_on: to=%0d par=%0d dv=%0d want 0 1 1", to, c, e);
        end
        run_frame(8, 1, 0, 0, 0, 0, 5, a, b, c, d, e, to);
        checks++;
        if (to || c != 0 || e != 1) begin
            failures++;
            $display("FAIL par_en_late_off: to=%0d par=%0d dv=%0d want 0 0 1", to, c, e);
        end
        par_en = 1'b0;
    endtask

    task automatic test_idle_stale();
        int bad;
        bad = 0;
        rx_in = 1'b1;
        prescale = 6'd8;
        force_stale = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            if (outs() !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0 || edge_cnt !== 6'd6) begin
            failures++;
            $display("FAIL idle_stale: bad_cycles=%0d edge_cnt=%0d want 0 6", bad, edge_cnt);
        end
        force_stale = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset_mid_frame();
        int a, b, c, d, e, s_dv;
        bit to, hit;
        s_dv = n_dv;
        hit = 1'b0;
        prescale = 6'd8; par_en = 1'b0; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        rx_in = 1'b0;
        repeat (2) @(negedge CLK);
        rx_in = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (bit_cnt == 4'd4 && edge_cnt == 6'd2) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit || deser_en !== 1'b0 || edge_bit_cnt_en !== 1'b1) begin
            failures++;
            $display("FAIL reach_data_bit4: hit=%0d cnt_en=%b want 1 1", hit, edge_bit_cnt_en);
        end
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if (outs() !== 8'h00) begin
            failures++;
            $display("FAIL async_reset: got %b want 00000000", outs());
        end
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (20) @(negedge CLK);
        #1;
        checks++;
        if (n_dv != s_dv || rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_abandon: dv=%0d busy=%b want 0 0", n_dv - s_dv, rx_busy);
        end
        run_frame(8, 0, 0, 0, 0, 0, 0, a, b, c, d, e, to);
        checks++;
        if (to || b != 8 || e != 1) begin
            failures++;
            $display("FAIL post_reset_frame: to=%0d deser=%0d dv=%0d want 0 8 1", to, b, e);
        end
    endtask

    task automatic test_monitors();
        checks++;
        if (n_bad_deser != 0) begin
            failures++;
            $display("FAIL deser_position: %0d pulses off CHK want 0", n_bad_deser);
        end
        checks++;
        if (n_bad_idle != 0) begin
            failures++;
            $display("FAIL strobe_outside_frame: %0d cycles want 0", n_bad_idle);
        end
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_start_glitch();
        test_parity_err();
        test_stop_err();
        test_back_to_back();
        test_par_en_sampling();
        test_idle_stale();
        test_reset_mid_frame();
        test_monitors();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
